// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with fixed read/write latency
//
// Word-organised 32-bit RAM behind a valid/ready request channel and a
// valid/ready response channel. One request is in flight at a time.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr              byte address (must be word aligned and in range)
//   req_wdata/req_wstrb   write data and per-byte-lane enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data (0 for writes and errors)
//   rsp_error             misaligned or out-of-range request
module mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam int DEPTH   = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [1:0]            state;
  logic [CW-1:0]         lat_cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_wstrb;

  logic                  accept;
  logic                  req_err;
  logic [CW-1:0]         req_lat_m1;

  // "fire" marks the edge at which the access really happens (write commit or
  // read sample) and the response becomes valid.
  logic                  fire;
  logic                  fire_write;
  logic [ADDR_WIDTH-1:0] fire_addr;
  logic [31:0]           fire_wdata;
  logic [3:0]            fire_wstrb;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // Shift-based range test keeps the expression legal for any ADDR_WIDTH.
  assign req_err    = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign req_lat_m1 = req_write ? CW'(WRITE_LATENCY - 1) : CW'(READ_LATENCY - 1);

  // With a latency of 1 the access fires on the accept edge itself, so it has
  // to use the live request inputs rather than the latched copy.
  always_comb begin
    fire       = 1'b0;
    fire_write = lat_write;
    fire_addr  = lat_addr;
    fire_wdata = lat_wdata;
    fire_wstrb = lat_wstrb;
    if (state == S_IDLE) begin
      fire_write = req_write;
      fire_addr  = req_addr[ADDR_WIDTH+1:2];
      fire_wdata = req_wdata;
      fire_wstrb = req_wstrb;
      fire       = accept && !req_err && (req_lat_m1 == '0);
    end else if (state == S_WAIT) begin
      fire = (lat_cnt == CW'(1));
    end
  end

  // RAM contents survive reset; a write cut off by reset never commits.
  always_ff @(posedge clk) begin
    if (!reset && fire && fire_write) begin
      for (int i = 0; i < 4; i++) begin
        if (fire_wstrb[i]) begin
          mem[fire_addr][8*i +: 8] <= fire_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_wstrb <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            lat_cnt   <= req_lat_m1;
            if (req_err) begin
              state     <= S_RESP;
              rsp_error <= 1'b1;
              rsp_rdata <= 32'd0;
            end else if (fire) begin
              state     <= S_RESP;
              rsp_error <= 1'b0;
              rsp_rdata <= fire_write ? 32'd0 : mem[fire_addr];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - CW'(1);
          if (fire) begin
            state     <= S_RESP;
            rsp_error <= 1'b0;
            rsp_rdata <= fire_write ? 32'd0 : mem[fire_addr];
          end
        end
        S_RESP: begin
          // Data and error are left untouched here so they stay stable under backpressure.
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's unified instruction/data memory port.
- Accepts one read or write request at a time over a valid/ready request channel.
- Models a fixed, parameterised access latency and returns exactly one response per request over a valid/ready response channel.
- Sits between the core datapath (address from PC or ALU result, write data from the register file) and a word-organised RAM array held inside this block.

Parameters:
- ADDR_WIDTH, 10, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2, cycles from request acceptance to read response valid; must be >= 1.
- WRITE_LATENCY, 1, cycles from request acceptance to write response valid; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_error  out  1  request was misaligned or out of range.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, on ports clk and reset.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE, latency counter=0.
- Reset does not clear the RAM contents.
- States:
  - IDLE: req_ready=1. On req_valid, latch write, addr, wdata and wstrb, then go to WAIT; for an error request go directly to RESP.
  - WAIT: req_ready=0. Count down the latency.
  - RESP: req_ready=0, rsp_valid=1. On rsp_ready, go to IDLE.
- Acceptance: a request is accepted at the rising edge where req_valid && req_ready; call that cycle T. Request inputs are ignored at all other times.
- Latency: for a valid request, rsp_valid first rises at T+LAT, where LAT = READ_LATENCY for reads and WRITE_LATENCY for writes. With LAT=1 the block passes through WAIT for zero cycles.
- Errors:
  - An error is req_addr[1:0] != 0, or req_addr[31:ADDR_WIDTH+2] != 0.
  - An error request produces rsp_valid at T+1 regardless of latency, with rsp_error=1 and rsp_rdata=0.
  - The RAM is never written by an error request.
- Write commit: the enabled byte lanes are written at the same edge that raises rsp_valid. A read accepted after that response sees the new data. wstrb=0 is legal: no RAM change, but a normal response is still returned.
- Read sampling: data is sampled from the RAM at the edge that raises rsp_valid.
- Backpressure: rsp_rdata and rsp_error stay stable while rsp_valid && !rsp_ready.
- Handshake completion: on rsp_valid && rsp_ready the block drops rsp_valid and returns to IDLE, so req_ready=1 on the next cycle. There is no same-cycle turnaround: the minimum spacing between accepted requests is LAT+1 cycles.
- Reset mid-operation: the block returns to IDLE next edge and drops the in-flight request. A write not yet committed is not committed.
- Latency counter: a counter of clog2(max(READ_LATENCY, WRITE_LATENCY))+1 bits. It is loaded with LAT-1 on accept and decrements in WAIT; RESP is entered when it reaches 0.
- Never more than one outstanding request.

Test Plan:
- Reset then idle: reset high 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- Write then read, READ_LATENCY=2, WRITE_LATENCY=1:
  - Write addr 0x10, data 0xDEADBEEF, wstrb 0xF accepted at T -> rsp_valid at T+1 with rdata 0.
  - Read of 0x10 accepted next -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, error 0.
- Byte strobe: write 0x11223344 to 0x20 with wstrb 0xF, then 0x000000AA with wstrb 0x1 -> read of 0x20 returns 0x112233AA.
- Misaligned and out-of-range:
  - Read 0x22 -> rsp_valid at T+1, error=1, rdata 0.
  - Write 0x1000 with ADDR_WIDTH=10 -> error=1, and a subsequent read of 0x000 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles on a read response -> rsp_valid, rdata and error stay constant and req_ready stays 0. After rsp_ready=1 for one cycle, req_ready=1 on the next cycle.
- Reset mid-write: WRITE_LATENCY=3, write 0x55 to 0x30, reset at T+1 -> no response is produced, and a later read of 0x30 returns the old value.
